ifq_param: RTL and testbench
============================

Name: ifq_param

Overview:
Parametrised instruction fetch queue, the successor of the fixed 4-line/4-word IFQ. It sits between the I-cache line interface and the decoder. It issues line requests ahead of consumption, with credits limited by free lines plus outstanding requests, and keeps in-order cache responses. On a branch redirect it discards in-flight stale lines and starts delivery at any word offset inside the target line.

Parameters:
DEPTH, 4, number of queued lines (power of 2, >=2)
WPL, 4, 32-bit words per cache line (power of 2, >=2)
MAX_OUT, 4, max outstanding cache requests (<=DEPTH)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
Pc_in  out  32  line-aligned fetch address to cache
Rd_en_cache  out  1  cache request; accepted in the same cycle it is high
Dout  in  32*WPL  returned line; word0 in MSBs
Dout_valid  in  1  response valid; responses return in request order
Pc_out  out  32  PC of Inst
Inst  out  32  instruction at queue head
Empty  out  1  no valid instruction at head
Rd_en  in  1  pop head instruction
Jmp_branch_address  in  32  redirect target
Jmp_branch_valid  in  1  redirect strobe

Behaviour:
- Reset (reset==0 at a clk edge): Pc_in=0, Rd_en_cache=0, Pc_out=0, Inst=0, Empty=1, pointers/counters=0, line storage=0, FSM=IDLE. The cache shares this reset, so no pre-reset responses return.
- Pointers: rptr/wptr carry log2(DEPTH)+1 bits (wrap bit). The read word offset has log2(WPL) bits. LINE_BYTES=4*WPL.
- Queue state: empty when rptr==wptr. Full when the index bits are equal and the wrap bits differ.
- Credit: credit = DEPTH - occupied_lines - outstanding.
- Request condition: Rd_en_cache = (state!=IDLE) & credit>0 & outstanding<MAX_OUT & ~Jmp_branch_valid.
- On each request: Pc_in += LINE_BYTES and outstanding increments.
- Response handling: a Dout_valid with drop_cnt==0 writes Dout at wptr, advances wptr, and decrements outstanding. A Dout_valid with drop_cnt>0 is discarded and decrements both drop_cnt and outstanding. A Dout_valid with outstanding==0 is ignored.
- Output timing: written data is visible at the head one cycle after the write (Empty falls the next cycle).
- Pop: Rd_en & ~Empty advances the offset and sets Pc_out+=4. At the last word (offset==WPL-1) the offset wraps to 0 and rptr advances, freeing a line. Rd_en while Empty is ignored.
- Redirect (Jmp_branch_valid): highest priority; Rd_en, Dout_valid writes and requests in that cycle are ignored. Next-cycle effects:
  - rptr=wptr=0, Empty=1
  - offset = address[log2(LINE_BYTES)-1:2], Pc_out = address with bits[1:0] forced to 0
  - Pc_in = address aligned down to LINE_BYTES
  - drop_cnt = outstanding (a response coinciding with the redirect is also discarded and excluded from the count)
- FSM:
  - IDLE -> FETCH one cycle after reset release.
  - FETCH -> STALL when credit==0.
  - STALL -> FETCH when a pop frees a line.
  - Any state -> FLUSH on redirect with drop_cnt>0.
  - FLUSH -> FETCH when drop_cnt reaches 0.
  - Requests are allowed in FLUSH.
  - A redirect during FLUSH reloads drop_cnt = outstanding.
- Simultaneous write and pop of the last word are both applied. Occupancy and credit are updated consistently in that cycle.

Optional Feature:
IFQ_BYPASS_EN defined:
- When the queue is empty and a non-dropped Dout_valid arrives, Empty=0 in the same cycle.
- Inst is the Dout word at the current offset; Pc_out is unchanged.
- A simultaneous Rd_en consumes that word; the line is still written.
IFQ_BYPASS_EN undefined: the one-cycle write-to-head latency applies always.

Decomposition:
- Package ifq_pkg: FSM state encoding (IDLE, FETCH, STALL, FLUSH), WORD_W=32, a clog2 function, and LINE_BYTES derivation.
- Sub-module ifq_line_mem: DEPTH x (32*WPL) registered storage with a write port and a word-select read mux. It is the generalisation of the old 4:1 word muxes.

Test Plan:
1. Default parameters; release reset; cache returns line {A,B,C,D} for 0x0 three cycles after request -> requests at Pc_in=0x00,0x10,0x20,0x30 then Rd_en_cache=0. After the response: Inst=A, Pc_out=0x0; pops give Pc_out 0x4, 0x8, 0xC.
2. No pops, four responses -> Rd_en_cache stays 0 (STALL). Pop four words -> Rd_en_cache=1 with Pc_in=0x40 in the following cycle.
3. Two outstanding requests, redirect to 0x108 -> Empty=1 and Pc_in=0x100. The two stale lines are dropped. The next line {W0..W3} gives Inst=W2, Pc_out=0x108; after one pop Pc_out=0x10C; the next pop advances to line 0x110.
4. Jmp_branch_valid with Dout_valid and Rd_en in the same cycle -> data discarded, no pop, redirect applied as in scenario 3.
5. reset=0 mid-operation with three outstanding requests and a partial line -> all outputs return to reset values. Fetch restarts at 0x0 two cycles after release.
6. With IFQ_BYPASS_EN, empty queue with response {A..D} at offset 1 -> Empty=0 and Inst=B in the same cycle. Without the macro -> Empty=0 one cycle later.

Source files
------------

// File: rtl/ifq_pkg.sv
// Shared types and helpers for the parametrised instruction fetch queue.
package ifq_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    STALL = 2'd2,
    FLUSH = 2'd3
  } ifq_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int line_bytes(input int wpl);
    return (WORD_W / 8) * wpl;
  endfunction

endpackage

// File: rtl/ifq_line_mem.sv
// DEPTH x line storage with one write port and a word-select read mux.
module ifq_line_mem
  import ifq_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int WPL   = 4,
  localparam int AW    = clog2(DEPTH),
  localparam int OW    = clog2(WPL)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [WORD_W*WPL-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  input  logic [OW-1:0]         rd_word,
  output logic [WORD_W-1:0]     rd_data
);

  logic [WORD_W*WPL-1:0] lines [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) lines[i] <= '0;
    end else if (wr_en) begin
      lines[wr_addr] <= wr_data;
    end
  end

  // Word 0 occupies the MSBs of a line, so word k sits WPL-1-k slots above bit 0.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < WPL; k++) begin
      if (rd_word == OW'(k)) rd_data = lines[rd_addr][WORD_W*(WPL-1-k) +: WORD_W];
    end
  end

endmodule

// File: rtl/ifq_param.sv
// Parametrised instruction fetch queue between the I-cache line port and the decoder.
// Define IFQ_BYPASS_EN to forward a response straight to an empty head in the same cycle.
module ifq_param
  import ifq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int WPL     = 4,
  parameter int MAX_OUT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [31:0]           Pc_in,
  output logic                  Rd_en_cache,
  input  logic [WORD_W*WPL-1:0] Dout,
  input  logic                  Dout_valid,
  output logic [31:0]           Pc_out,
  output logic [31:0]           Inst,
  output logic                  Empty,
  input  logic                  Rd_en,
  input  logic [31:0]           Jmp_branch_address,
  input  logic                  Jmp_branch_valid
);

  localparam int PW  = clog2(DEPTH);
  localparam int OW  = clog2(WPL);
  localparam int CW  = clog2(MAX_OUT + 1);
  localparam int LB  = line_bytes(WPL);
  localparam int LBW = clog2(LB);

  ifq_state_e        state;
  logic [PW:0]       rptr, wptr, occupied;
  logic [OW-1:0]     offset;
  logic [CW-1:0]     outstanding, drop_cnt, drop_nxt, flush_cnt;
  logic [WORD_W-1:0] mem_word;
  logic              resp_any, resp, resp_keep, resp_drop;
  logic              q_empty, bypass, pop, free_line;
  int                credit, credit_nxt;

  assign resp_any  = Dout_valid && (outstanding != '0);
  assign resp      = resp_any && !Jmp_branch_valid;
  assign resp_keep = resp && (drop_cnt == '0);
  assign resp_drop = resp && (drop_cnt != '0);
  assign q_empty   = (rptr == wptr);
  assign Empty     = q_empty && !bypass;
  assign pop       = Rd_en && !Empty && !Jmp_branch_valid;
  assign free_line = pop && (&offset);
  assign occupied  = wptr - rptr;
  assign drop_nxt  = drop_cnt - CW'(resp_drop);
  // A response arriving with the redirect is already stale and is not counted.
  assign flush_cnt = outstanding - CW'(resp_any);

  assign credit      = DEPTH - int'(occupied) - int'(outstanding);
  assign credit_nxt  = credit + int'(free_line) + int'(resp_drop) - int'(Rd_en_cache);
  assign Rd_en_cache = (state != IDLE) && (credit > 0) && (int'(outstanding) < MAX_OUT)
                       && !Jmp_branch_valid;

  ifq_line_mem #(
    .DEPTH(DEPTH),
    .WPL  (WPL)
  ) u_mem (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (resp_keep),
    .wr_addr(wptr[PW-1:0]),
    .wr_data(Dout),
    .rd_addr(rptr[PW-1:0]),
    .rd_word(offset),
    .rd_data(mem_word)
  );

`ifdef IFQ_BYPASS_EN
  logic [WORD_W-1:0] dout_word;

  always_comb begin
    dout_word = '0;
    for (int k = 0; k < WPL; k++) begin
      if (offset == OW'(k)) dout_word = Dout[WORD_W*(WPL-1-k) +: WORD_W];
    end
  end

  assign bypass = q_empty && resp_keep;
  assign Inst   = bypass ? dout_word : mem_word;
`else
  assign bypass = 1'b0;
  assign Inst   = mem_word;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      Pc_in       <= '0;
      Pc_out      <= '0;
      rptr        <= '0;
      wptr        <= '0;
      offset      <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (Jmp_branch_valid) begin
      rptr        <= '0;
      wptr        <= '0;
      offset      <= Jmp_branch_address[LBW-1:2];
      Pc_out      <= {Jmp_branch_address[31:2], 2'b00};
      Pc_in       <= Jmp_branch_address & ~32'(LB - 1);
      outstanding <= flush_cnt;
      drop_cnt    <= flush_cnt;
      state       <= (flush_cnt != '0) ? FLUSH : FETCH;
    end else begin
      if (Rd_en_cache) Pc_in <= Pc_in + 32'(LB);
      outstanding <= outstanding + CW'(Rd_en_cache) - CW'(resp);
      drop_cnt    <= drop_nxt;
      if (resp_keep) wptr <= wptr + (PW+1)'(1);
      if (pop) begin
        offset <= offset + OW'(1);
        Pc_out <= Pc_out + 32'd4;
        if (free_line) rptr <= rptr + (PW+1)'(1);
      end
      case (state)
        IDLE:         state <= FETCH;
        FETCH, STALL: state <= (credit_nxt == 0) ? STALL : FETCH;
        FLUSH:        if (drop_nxt == '0) state <= FETCH;
        default:      state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifq_param.sv
// Directed self-checking bench for ifq_param at default parameters; honours IFQ_BYPASS_EN.
module tb_ifq_param;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  Pc_in;
  logic         Rd_en_cache;
  logic [127:0] Dout;
  logic         Dout_valid;
  logic [31:0]  Pc_out;
  logic [31:0]  Inst;
  logic         Empty;
  logic         Rd_en;
  logic [31:0]  Jmp_branch_address;
  logic         Jmp_branch_valid;

  int checks = 0;
  int passed = 0;

  ifq_param #(
    .DEPTH  (4),
    .WPL    (4),
    .MAX_OUT(4)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .Pc_in             (Pc_in),
    .Rd_en_cache       (Rd_en_cache),
    .Dout              (Dout),
    .Dout_valid        (Dout_valid),
    .Pc_out            (Pc_out),
    .Inst              (Inst),
    .Empty             (Empty),
    .Rd_en             (Rd_en),
    .Jmp_branch_address(Jmp_branch_address),
    .Jmp_branch_valid  (Jmp_branch_valid)
  );

  always #5 clk = ~clk;

  // Instruction stored at a given PC: easy to recognise in a trace.
  function automatic logic [31:0] inst_at(input logic [31:0] pc);
    return 32'hC0DE_0000 | pc;
  endfunction

  function automatic logic [127:0] line_at(input logic [31:0] base);
    return {inst_at(base), inst_at(base + 32'd4), inst_at(base + 32'd8), inst_at(base + 32'd12)};
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b0; Rd_en = 1'b0; Dout_valid = 1'b0; Dout = '0;
    Jmp_branch_valid = 1'b0; Jmp_branch_address = '0;
    step(); step(); #1;
    checks++; if (Pc_in !== 32'h0) $display("[TB] FAIL reset_pc_in: got %h expected 00000000", Pc_in); else passed++;
    checks++; if (Rd_en_cache !== 1'b0) $display("[TB] FAIL reset_rd_en_cache: got %b expected 0", Rd_en_cache); else passed++;
    checks++; if (Pc_out !== 32'h0) $display("[TB] FAIL reset_pc_out: got %h expected 00000000", Pc_out); else passed++;
    checks++; if (Inst !== 32'h0) $display("[TB] FAIL reset_inst: got %h expected 00000000", Inst); else passed++;
    checks++; if (Empty !== 1'b1) $display("[TB] FAIL reset_empty: got %b expected 1", Empty); else passed++;
  endtask

  task automatic test_fetch();
    reset = 1'b1; #1;
    checks++; if (Rd_en_cache !== 1'b0) $display("[TB] FAIL idle_no_req: got %b expected 0", Rd_en_cache); else passed++;
    step();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (Rd_en_cache !== 1'b1 || Pc_in !== 32'(i * 16))
        $display("[TB] FAIL fetch_req%0d: got req=%b pc=%h expected req=1 pc=%h", i, Rd_en_cache, Pc_in, 32'(i * 16));
      else passed++;
      step();
    end
    Dout = line_at(32'h0); Dout_valid = 1'b1; #1;
    checks++; if (Rd_en_cache !== 1'b1 || Pc_in !== 32'h30) $display("[TB] FAIL fetch_req3: got req=%b pc=%h expected req=1 pc=00000030", Rd_en_cache, Pc_in); else passed++;
`ifdef IFQ_BYPASS_EN
    checks++; if (Empty !== 1'b0 || Inst !== inst_at(32'h0)) $display("[TB] FAIL fetch_bypass: got empty=%b inst=%h expected empty=0 inst=%h", Empty, Inst, inst_at(32'h0)); else passed++;
`else
    checks++; if (Empty !== 1'b1) $display("[TB] FAIL fetch_write_latency: got empty=%b expected 1", Empty); else passed++;
`endif
    step(); Dout_valid = 1'b0; #1;
    checks++; if (Rd_en_cache !== 1'b0) $display("[TB] FAIL fetch_credit_out: got %b expected 0", Rd_en_cache); else passed++;
    checks++;
    if (Empty !== 1'b0 || Inst !== inst_at(32'h0) || Pc_out !== 32'h0)
      $display("[TB] FAIL fetch_head: got empty=%b inst=%h pc=%h expected empty=0 inst=%h pc=00000000", Empty, Inst, Pc_out, inst_at(32'h0));
    else passed++;
    Rd_en = 1'b1;
    step();
    for (int i = 1; i < 4; i++) begin
      if (i == 3) Rd_en = 1'b0;
      #1;
      checks++;
      if (Pc_out !== 32'(4 * i) || Inst !== inst_at(32'(4 * i)))
        $display("[TB] FAIL fetch_pop%0d: got pc=%h inst=%h expected pc=%h inst=%h", i, Pc_out, Inst, 32'(4 * i), inst_at(32'(4 * i)));
      else passed++;
      step();
    end
  endtask

  task automatic test_stall();
    for (int i = 1; i < 4; i++) begin
      Dout = line_at(32'(16 * i)); Dout_valid = 1'b1; #1;
      checks++; if (Rd_en_cache !== 1'b0) $display("[TB] FAIL stall_resp%0d: got req=%b expected 0", i, Rd_en_cache); else passed++;
      step();
    end
    Dout_valid = 1'b0; #1;
    checks++; if (Rd_en_cache !== 1'b0) $display("[TB] FAIL stall_full: got req=%b expected 0", Rd_en_cache); else passed++;
    checks++; if (Inst !== inst_at(32'hC) || Pc_out !== 32'hC) $display("[TB] FAIL stall_head: got inst=%h pc=%h expected inst=%h pc=0000000c", Inst, Pc_out, inst_at(32'hC)); else passed++;
    Rd_en = 1'b1;
    step();
    Rd_en = 1'b0; #1;
    checks++; if (Rd_en_cache !== 1'b1 || Pc_in !== 32'h40) $display("[TB] FAIL stall_release: got req=%b pc=%h expected req=1 pc=00000040", Rd_en_cache, Pc_in); else passed++;
    checks++;
    if (Empty !== 1'b0 || Inst !== inst_at(32'h10) || Pc_out !== 32'h10)
      $display("[TB] FAIL stall_next_line: got empty=%b inst=%h pc=%h expected empty=0 inst=%h pc=00000010", Empty, Inst, Pc_out, inst_at(32'h10));
    else passed++;
    step(); #1;
    checks++; if (Rd_en_cache !== 1'b0) $display("[TB] FAIL stall_recredit: got req=%b expected 0", Rd_en_cache); else passed++;
    step();
  endtask

  task automatic test_redirect();
    reset = 1'b0; step(); reset = 1'b1;
    step(); step(); step();
    Jmp_branch_address = 32'h108; Jmp_branch_valid = 1'b1; #1;
    checks++; if (Rd_en_cache !== 1'b0) $display("[TB] FAIL redir_blocks_req: got %b expected 0", Rd_en_cache); else passed++;
    step();
    Jmp_branch_valid = 1'b0; #1;
    checks++;
    if (Empty !== 1'b1 || Pc_in !== 32'h100 || Pc_out !== 32'h108 || Rd_en_cache !== 1'b1)
      $display("[TB] FAIL redir_state: got empty=%b pc_in=%h pc_out=%h req=%b expected 1 00000100 00000108 1", Empty, Pc_in, Pc_out, Rd_en_cache);
    else passed++;
    step();
    for (int i = 0; i < 2; i++) begin
      Dout = {4{32'hDEAD_BEEF}}; Dout_valid = 1'b1; #1;
      checks++; if (Empty !== 1'b1) $display("[TB] FAIL redir_drop%0d: got empty=%b expected 1", i, Empty); else passed++;
      step();
    end
    Dout = line_at(32'h100); #1;
`ifdef IFQ_BYPASS_EN
    checks++; if (Empty !== 1'b0 || Inst !== inst_at(32'h108)) $display("[TB] FAIL redir_bypass: got empty=%b inst=%h expected empty=0 inst=%h", Empty, Inst, inst_at(32'h108)); else passed++;
`else
    checks++; if (Empty !== 1'b1) $display("[TB] FAIL redir_write_latency: got empty=%b expected 1", Empty); else passed++;
`endif
    step();
    Dout_valid = 1'b0; #1;
    checks++;
    if (Empty !== 1'b0 || Inst !== inst_at(32'h108) || Pc_out !== 32'h108)
      $display("[TB] FAIL redir_target: got empty=%b inst=%h pc=%h expected empty=0 inst=%h pc=00000108", Empty, Inst, Pc_out, inst_at(32'h108));
    else passed++;
    Rd_en = 1'b1;
    step(); #1;
    checks++; if (Pc_out !== 32'h10C || Inst !== inst_at(32'h10C)) $display("[TB] FAIL redir_pop: got pc=%h inst=%h expected pc=0000010c inst=%h", Pc_out, Inst, inst_at(32'h10C)); else passed++;
    step();
    Rd_en = 1'b0; #1;
    checks++; if (Empty !== 1'b1 || Pc_out !== 32'h110) $display("[TB] FAIL redir_line_end: got empty=%b pc=%h expected empty=1 pc=00000110", Empty, Pc_out); else passed++;
    Dout = line_at(32'h110); Dout_valid = 1'b1;
    step();
    Dout_valid = 1'b0; #1;
    checks++;
    if (Empty !== 1'b0 || Inst !== inst_at(32'h110) || Pc_out !== 32'h110)
      $display("[TB] FAIL redir_next_line: got empty=%b inst=%h pc=%h expected empty=0 inst=%h pc=00000110", Empty, Inst, Pc_out, inst_at(32'h110));
    else passed++;
    step();
  endtask

  task automatic test_redirect_collision();
    Jmp_branch_address = 32'h204; Jmp_branch_valid = 1'b1;
    Dout = line_at(32'h120); Dout_valid = 1'b1; Rd_en = 1'b1; #1;
    checks++; if (Rd_en_cache !== 1'b0) $display("[TB] FAIL coll_blocks_req: got %b expected 0", Rd_en_cache); else passed++;
    step();
    Jmp_branch_valid = 1'b0; Dout_valid = 1'b0; Rd_en = 1'b0; #1;
    checks++;
    if (Empty !== 1'b1 || Pc_out !== 32'h204 || Pc_in !== 32'h200)
      $display("[TB] FAIL coll_state: got empty=%b pc_out=%h pc_in=%h expected 1 00000204 00000200", Empty, Pc_out, Pc_in);
    else passed++;
    Dout = {4{32'hDEAD_BEEF}}; Dout_valid = 1'b1;
    step(); #1;
    checks++; if (Empty !== 1'b1) $display("[TB] FAIL coll_drop: got empty=%b expected 1", Empty); else passed++;
    step();
    Dout = line_at(32'h200); #1;
`ifdef IFQ_BYPASS_EN
    checks++; if (Empty !== 1'b0 || Inst !== inst_at(32'h204)) $display("[TB] FAIL coll_bypass: got empty=%b inst=%h expected empty=0 inst=%h", Empty, Inst, inst_at(32'h204)); else passed++;
`else
    checks++; if (Empty !== 1'b1) $display("[TB] FAIL coll_write_latency: got empty=%b expected 1", Empty); else passed++;
`endif
    step();
    Dout_valid = 1'b0; #1;
    checks++;
    if (Empty !== 1'b0 || Inst !== inst_at(32'h204) || Pc_out !== 32'h204)
      $display("[TB] FAIL coll_target: got empty=%b inst=%h pc=%h expected empty=0 inst=%h pc=00000204", Empty, Inst, Pc_out, inst_at(32'h204));
    else passed++;
    step();
  endtask

  task automatic test_mid_reset();
    reset = 1'b0;
    step(); #1;
    checks++; if (Pc_in !== 32'h0 || Rd_en_cache !== 1'b0) $display("[TB] FAIL mid_reset_fetch: got pc_in=%h req=%b expected 00000000 0", Pc_in, Rd_en_cache); else passed++;
    checks++;
    if (Pc_out !== 32'h0 || Inst !== 32'h0 || Empty !== 1'b1)
      $display("[TB] FAIL mid_reset_head: got pc_out=%h inst=%h empty=%b expected 00000000 00000000 1", Pc_out, Inst, Empty);
    else passed++;
    reset = 1'b1; #1;
    checks++; if (Rd_en_cache !== 1'b0) $display("[TB] FAIL mid_reset_idle: got %b expected 0", Rd_en_cache); else passed++;
    step(); #1;
    checks++; if (Rd_en_cache !== 1'b1 || Pc_in !== 32'h0) $display("[TB] FAIL mid_reset_restart: got req=%b pc=%h expected req=1 pc=00000000", Rd_en_cache, Pc_in); else passed++;
  endtask

  task automatic test_bypass();
    Jmp_branch_address = 32'h4; Jmp_branch_valid = 1'b1; #1;
    checks++; if (Rd_en_cache !== 1'b0) $display("[TB] FAIL byp_redir_req: got %b expected 0", Rd_en_cache); else passed++;
    step();
    Jmp_branch_valid = 1'b0; #1;
    checks++;
    if (Rd_en_cache !== 1'b1 || Pc_in !== 32'h0 || Pc_out !== 32'h4 || Empty !== 1'b1)
      $display("[TB] FAIL byp_setup: got req=%b pc_in=%h pc_out=%h empty=%b expected 1 00000000 00000004 1", Rd_en_cache, Pc_in, Pc_out, Empty);
    else passed++;
    step(); step();
    Dout = line_at(32'h0); Dout_valid = 1'b1; Rd_en = 1'b1; #1;
`ifdef IFQ_BYPASS_EN
    checks++;
    if (Empty !== 1'b0 || Inst !== inst_at(32'h4) || Pc_out !== 32'h4)
      $display("[TB] FAIL byp_same_cycle: got empty=%b inst=%h pc=%h expected empty=0 inst=%h pc=00000004", Empty, Inst, Pc_out, inst_at(32'h4));
    else passed++;
`else
    checks++; if (Empty !== 1'b1) $display("[TB] FAIL byp_no_bypass: got empty=%b expected 1", Empty); else passed++;
`endif
    step();
    Dout_valid = 1'b0; Rd_en = 1'b0; #1;
`ifdef IFQ_BYPASS_EN
    checks++;
    if (Empty !== 1'b0 || Inst !== inst_at(32'h8) || Pc_out !== 32'h8)
      $display("[TB] FAIL byp_consumed: got empty=%b inst=%h pc=%h expected empty=0 inst=%h pc=00000008", Empty, Inst, Pc_out, inst_at(32'h8));
    else passed++;
`else
    checks++;
    if (Empty !== 1'b0 || Inst !== inst_at(32'h4) || Pc_out !== 32'h4)
      $display("[TB] FAIL byp_next_cycle: got empty=%b inst=%h pc=%h expected empty=0 inst=%h pc=00000004", Empty, Inst, Pc_out, inst_at(32'h4));
    else passed++;
`endif
    step();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_stall();
    test_redirect();
    test_redirect_collision();
    test_mid_reset();
    test_bypass();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, limit 200000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
